// File: rtl/jk_bank_sequencer.sv
// Command sequencer driving J/K excitation into a bank of WIDTH JK flip-flops.
// Define JK_SEQ_WRAP_EN for modulo counting; otherwise up/down counts saturate.
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;

  logic [WIDTH-1:0]   upT, dnT;
  logic               upSat, dnSat;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          if (cmd_op == OP_LOAD) begin
            remaining_d = LEN_W'(1);
            state_d     = RUN;
          end else if (cmd_len != '0) begin
            remaining_d = cmd_len;
            state_d     = RUN;
          end else begin
            remaining_d = '0;
            state_d     = DONE;
          end
        end
      end
      RUN: begin
        remaining_d = remaining_q - LEN_W'(1);
        if (abort || remaining_q == LEN_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_HOLD;
      data_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
    end
  end

  // Toggle enables of a synchronous binary counter: bit i toggles when all lower bits carry/borrow.
  always_comb begin
    upT    = '0;
    dnT    = '0;
    upT[0] = 1'b1;
    dnT[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      upT[i] = upT[i-1] & q_fb[i-1];
      dnT[i] = dnT[i-1] & ~q_fb[i-1];
    end
`ifdef JK_SEQ_WRAP_EN
    upSat = 1'b0;
    dnSat = 1'b0;
`else
    upSat = &q_fb;
    dnSat = ~|q_fb;
`endif
  end

  always_comb begin
    j = '0;
    k = '0;
    if (state_q == RUN && !abort) begin
      case (op_q)
        OP_UP: begin
          if (!upSat) begin
            j = upT;
            k = upT;
          end
        end
        OP_DOWN: begin
          if (!dnSat) begin
            j = dnT;
            k = dnT;
          end
        end
        OP_LOAD: begin
          j = data_q;
          k = ~data_q;
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer with a behavioural 4-bit JK bank in the loop.
// Expected count sequences follow JK_SEQ_WRAP_EN the same way the design does.
module tb_jk_bank_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_len;
  logic       abort;
  logic [3:0] bank;
  logic [3:0] j;
  logic [3:0] k;
  logic       busy;
  logic       done;

  logic       bankSet;
  logic [3:0] bankVal;

  int assertCount;
  int failCount;

  logic [3:0] upExp [5];
  logic [3:0] dnExp [3];

  jk_bank_sequencer #(.WIDTH(4), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .abort     (abort),
    .q_fb      (bank),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // JK flip-flop bank; not reset by rst_n, preloadable from the bench.
  always @(posedge clk) begin
    if (bankSet) begin
      bank <= bankVal;
    end else begin
      for (int i = 0; i < 4; i++) begin
        case ({j[i], k[i]})
          2'b10:   bank[i] <= 1'b1;
          2'b01:   bank[i] <= 1'b0;
          2'b11:   bank[i] <= ~bank[i];
          default: bank[i] <= bank[i];
        endcase
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setBank(input logic [3:0] v);
    bankSet = 1'b1;
    bankVal = v;
    tick();
    bankSet = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] data, input logic [7:0] len);
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    cmd_valid = 1'b1;
    checkOutput("ready_before_accept", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_data = 4'h0;
    cmd_len = 8'd0;
    abort = 1'b0;
    bankSet = 1'b0;
    bankVal = 4'h0;
    assertCount = 0;
    failCount = 0;
`ifdef JK_SEQ_WRAP_EN
    upExp = '{4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010};
    dnExp = '{4'b0001, 4'b0000, 4'b1111};
`else
    upExp = '{4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    dnExp = '{4'b0001, 4'b0000, 4'b0000};
`endif

    // Reset state
    setBank(4'b0000);
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_j", 32'(j), 32'd0);
    checkOutput("rst_k", 32'(k), 32'd0);
    rst_n = 1'b1;
    tick();

    // Parallel load 1010
    applyStimulus(2'b11, 4'b1010, 8'd0);
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_ready", 32'(cmd_ready), 32'd0);
    checkOutput("load_j", 32'(j), 32'b1010);
    checkOutput("load_k", 32'(k), 32'b0101);
    checkOutput("load_done_early", 32'(done), 32'd0);
    tick();
    checkOutput("load_bank", 32'(bank), 32'b1010);
    checkOutput("load_done", 32'(done), 32'd1);
    checkOutput("load_done_j", 32'(j), 32'd0);
    tick();
    checkOutput("load_ready_back", 32'(cmd_ready), 32'd1);
    checkOutput("load_done_pulse", 32'(done), 32'd0);

    // Count up from 1101, five steps
    setBank(4'b1101);
    applyStimulus(2'b01, 4'h0, 8'd5);
    for (int s = 0; s < 5; s++) begin
      checkOutput("up_busy", 32'(busy), 32'd1);
      checkOutput("up_done_early", 32'(done), 32'd0);
      tick();
      checkOutput("up_step", 32'(bank), 32'(upExp[s]));
    end
    checkOutput("up_done", 32'(done), 32'd1);
    tick();

    // Count down from 0010, three steps
    setBank(4'b0010);
    applyStimulus(2'b10, 4'h0, 8'd3);
    checkOutput("dn_j_first", 32'(j), 32'b0011);
    for (int s = 0; s < 3; s++) begin
      tick();
      checkOutput("dn_step", 32'(bank), 32'(dnExp[s]));
    end
    checkOutput("dn_done", 32'(done), 32'd1);
    tick();

    // Abort in the fourth RUN cycle of a ten-step up count
    setBank(4'b0000);
    applyStimulus(2'b01, 4'h0, 8'd10);
    checkOutput("ab_j_first", 32'(j), 32'b0001);
    checkOutput("ab_k_first", 32'(k), 32'b0001);
    tick();
    tick();
    tick();
    abort = 1'b1;
    #1;
    checkOutput("ab_j", 32'(j), 32'd0);
    checkOutput("ab_k", 32'(k), 32'd0);
    checkOutput("ab_busy", 32'(busy), 32'd1);
    tick();
    abort = 1'b0;
    checkOutput("ab_done", 32'(done), 32'd1);
    checkOutput("ab_bank", 32'(bank), 32'b0011);
    tick();
    checkOutput("ab_ready", 32'(cmd_ready), 32'd1);

    // Zero-length up command
    applyStimulus(2'b01, 4'h0, 8'd0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    checkOutput("zero_j", 32'(j), 32'd0);
    checkOutput("zero_ready", 32'(cmd_ready), 32'd0);
    tick();
    checkOutput("zero_ready_back", 32'(cmd_ready), 32'd1);
    checkOutput("zero_bank", 32'(bank), 32'b0011);

    // cmd_valid held high through a whole command
    setBank(4'b0000);
    cmd_op = 2'b01;
    cmd_data = 4'h0;
    cmd_len = 8'd2;
    cmd_valid = 1'b1;
    tick();
    checkOutput("hold_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("hold_ready_run", 32'(cmd_ready), 32'd0);
    tick();
    checkOutput("hold_ready_done", 32'(cmd_ready), 32'd0);
    checkOutput("hold_bank1", 32'(bank), 32'd2);
    tick();
    checkOutput("hold_ready_idle", 32'(cmd_ready), 32'd1);
    checkOutput("hold_busy_idle", 32'(busy), 32'd0);
    tick();
    cmd_valid = 1'b0;
    checkOutput("hold_second_accept", 32'(busy), 32'd1);
    tick();
    tick();
    checkOutput("hold_bank2", 32'(bank), 32'd4);
    checkOutput("hold_done2", 32'(done), 32'd1);
    tick();

    // Reset pulsed mid-RUN
    setBank(4'b0000);
    applyStimulus(2'b01, 4'h0, 8'd10);
    tick();
    tick();
    checkOutput("mr_j_before", 32'(j), 32'b0001);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_j", 32'(j), 32'd0);
    checkOutput("mr_k", 32'(k), 32'd0);
    checkOutput("mr_busy", 32'(busy), 32'd0);
    checkOutput("mr_ready", 32'(cmd_ready), 32'd1);
    tick();
    checkOutput("mr_bank", 32'(bank), 32'b0010);
    checkOutput("mr_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("mr_idle_ready", 32'(cmd_ready), 32'd1);
    checkOutput("mr_idle_done", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
